// File: rtl/pipeline_stall_ctrl.sv
// Decode-stage stall/flush sequencer for a five-stage pipeline.
// It turns hazard, branch, interrupt and memory-busy events into per-stage enables and bubbles.
module pipeline_stall_ctrl #(
  parameter int POP_STALL_CYCLES = 2,
  parameter int INT_CYCLES       = 2,
  parameter int CNT_W            = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_use_n,
  input  logic       pop_case_n,
  input  logic       branch_taken,
  input  logic       int_req,
  input  logic       mem_busy,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       ex_mem_write_en,
  output logic       mem_wb_bubble,
  output logic       pc_sel_int,
  output logic       int_ack,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_POP = 2'b01,
    S_INT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               int_pend_q, int_pend_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    mem_wb_bubble   = 1'b0;
    pc_sel_int      = 1'b0;
    int_ack         = 1'b0;
    if (rst) begin
      state_d = S_RUN;
    end else if (mem_busy) begin
      // Whole pipeline holds; sequencing state is frozen until memory is ready.
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_bubble   = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (branch_taken) begin
            // A pending interrupt waits so the saved PC is the branch target.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (int_pend_q) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pc_write_en  = 1'b0;
            cnt_d        = CNT_W'(INT_CYCLES - 1);
            state_d      = S_INT;
          end else if (!pop_case_n) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            if (POP_STALL_CYCLES > 1) begin
              cnt_d   = CNT_W'(POP_STALL_CYCLES - 2);
              state_d = S_POP;
            end
          end else if (!load_use_n) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
          end
        end
        S_POP: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = S_RUN;
          end else begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            if (cnt_q == '0) state_d = S_RUN;
            else             cnt_d   = cnt_q - 1'b1;
          end
        end
        S_INT: begin
          if (cnt_q != '0) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pc_write_en  = 1'b0;
            cnt_d        = cnt_q - 1'b1;
          end else begin
            pc_sel_int = 1'b1;
            int_ack    = 1'b1;
            state_d    = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // A request on the acknowledge edge re-arms the pending flag.
  assign int_pend_d = int_req | (int_pend_q & ~int_ack);
  assign state      = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a cycle-level reference model predicts every output,
// a negedge monitor compares the DUT against the queued predictions.
module tb_pipeline_stall_ctrl;
  localparam int POP_N = 3;
  localparam int INT_N = 2;

  logic clk = 1'b0;
  logic rst, load_use_n, pop_case_n, branch_taken, int_req, mem_busy;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble;
  logic ex_mem_write_en, mem_wb_bubble, pc_sel_int, int_ack;
  logic [1:0] state;

  pipeline_stall_ctrl #(.POP_STALL_CYCLES(POP_N), .INT_CYCLES(INT_N), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load_use_n(load_use_n), .pop_case_n(pop_case_n),
    .branch_taken(branch_taken), .int_req(int_req), .mem_busy(mem_busy),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_write_en(ex_mem_write_en),
    .mem_wb_bubble(mem_wb_bubble), .pc_sel_int(pc_sel_int), .int_ack(int_ack), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Reference model: remaining cycles of each multi-cycle activity, plus the pending flag.
  int m_pop_left = 0;   // POP_STALL cycles still to come
  int m_int_left = 0;   // INT cycles still to come (ack on the last one)
  bit m_pend     = 0;

  // {pc_we, ifid_we, flush, bubble, exmem_we, wb_bubble, sel_int, ack, state}
  task automatic cycle(input bit lu_n, input bit pop_n, input bit br, input bit irq,
                       input bit mb, input bit r);
    bit pcw, ifw, fl, bub, exw, wbb, sel, ack;
    logic [1:0] st;
    @(posedge clk);
    #1;
    rst = r; load_use_n = lu_n; pop_case_n = pop_n; branch_taken = br;
    int_req = irq; mem_busy = mb;
    pcw = 1; ifw = 1; fl = 0; bub = 0; exw = 1; wbb = 0; sel = 0; ack = 0;
    st = (m_int_left > 0) ? 2'b10 : (m_pop_left > 0) ? 2'b01 : 2'b00;
    if (r) begin
      m_pop_left = 0; m_int_left = 0; m_pend = 0; st = 2'b00;
    end else begin
      if (mb) begin
        pcw = 0; ifw = 0; exw = 0; wbb = 1;
      end else if (m_int_left > 0) begin
        if (m_int_left > 1) begin fl = 1; bub = 1; pcw = 0; end
        else begin sel = 1; ack = 1; end
        m_int_left--;
      end else if (m_pop_left > 0) begin
        if (br) begin fl = 1; bub = 1; m_pop_left = 0; end
        else begin pcw = 0; ifw = 0; bub = 1; m_pop_left--; end
      end else if (br) begin
        fl = 1; bub = 1;
      end else if (m_pend) begin
        fl = 1; bub = 1; pcw = 0; m_int_left = INT_N;
      end else if (!pop_n) begin
        pcw = 0; ifw = 0; bub = 1; m_pop_left = POP_N - 1;
      end else if (!lu_n) begin
        pcw = 0; ifw = 0; bub = 1;
      end
      m_pend = irq | (m_pend & !ack);
    end
    exp_q.push_back({pcw, ifw, fl, bub, exw, wbb, sel, ack, st});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [9:0] act, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_write_en,
             mem_wb_bubble, pc_sel_int, int_ack, state};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outs t=%0t got=%b want=%b (pcw,ifw,fl,bub,exw,wbb,sel,ack,st)",
                 $time, act, exp_v);
      end
    end
  end

  initial begin
    rst = 1; load_use_n = 1; pop_case_n = 1; branch_taken = 0; int_req = 0; mem_busy = 0;
    cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    idle(3);
    cycle(0, 1, 0, 0, 0, 0);           // load-use
    idle(2);
    cycle(1, 0, 0, 0, 0, 0);           // POP stall
    idle(4);
    cycle(1, 1, 0, 1, 0, 0);           // interrupt pulse
    idle(5);
    cycle(1, 1, 1, 1, 0, 0);           // interrupt with branch
    idle(5);
    cycle(1, 0, 0, 0, 0, 0);           // POP stall with mem_busy inside
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1, 0);
    idle(4);
    cycle(1, 0, 0, 0, 0, 0);           // POP stall aborted by branch
    cycle(1, 1, 1, 0, 0, 0);
    idle(2);
    cycle(1, 1, 0, 1, 0, 0);           // reset mid-INT loses the interrupt
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    idle(4);
    cycle(1, 1, 0, 1, 0, 0);           // int_req held across ack re-pends
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    idle(6);
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(99) < 20) ? 1'b0 : 1'b1,
            ($urandom_range(99) < 12) ? 1'b0 : 1'b1,
            ($urandom_range(99) < 12) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 8)  ? 1'b1 : 1'b0,
            ($urandom_range(99) < 15) ? 1'b1 : 1'b0,
            ($urandom_range(199) < 3) ? 1'b1 : 1'b0);
    idle(2);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer side of the decode-stage hazard signals.
- Takes the active-low stall requests from the hazard detection logic, plus branch, interrupt and memory-busy events.
- Drives per-stage write enables, bubble and flush controls for the five-stage pipeline.
- Owns multi-cycle stall sequencing: POP stall and interrupt entry.

Parameters:
- POP_STALL_CYCLES, 2, total decode-freeze cycles for a POP data hazard (range 1..7).
- INT_CYCLES, 2, cycles spent in interrupt entry before vector load (range 1..7).
- CNT_W, 3, width of the internal sequence counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_use_n  in  1  0 = load-use hazard in decode (active-low stall request).
- pop_case_n  in  1  0 = POP data hazard in decode (active-low stall request).
- branch_taken  in  1  taken branch/jump resolved in execute this cycle.
- int_req  in  1  external interrupt request, level.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- pc_write_en  out  1  PC register load enable.
- if_id_write_en  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  select NOP control word into ID/EX.
- ex_mem_write_en  out  1  EX/MEM register enable.
- mem_wb_bubble  out  1  NOP into MEM/WB.
- pc_sel_int  out  1  PC mux selects interrupt vector.
- int_ack  out  1  one-cycle interrupt acknowledge.
- state  out  2  current FSM state for debug (00 RUN, 01 POP_STALL, 10 INT).

Behaviour:
- Outputs are combinational from the registered state/counter/int_pending and the current inputs. State, counter and int_pending update on the rising clk edge.
- While rst is high, outputs are forced to their reset values: all write enables 1; if_id_flush, id_ex_bubble, mem_wb_bubble, pc_sel_int and int_ack 0; state RUN; cnt 0; int_pending 0.
- Default (no event): write enables 1, all bubble/flush/int outputs 0.
- int_pending: set on any edge where int_req=1; cleared on the edge where int_ack=1. If int_req is still high at that edge, set wins (re-pending).
- mem_busy=1 overrides everything in every state:
  - pc_write_en, if_id_write_en and ex_mem_write_en are 0; mem_wb_bubble is 1; other outputs 0; int_ack suppressed.
  - state, cnt and int_pending do not advance; int_pending may still be set.
- RUN, mem_busy=0, priority highest first:
  1. branch_taken: pc_write_en=1, if_id_flush=1, id_ex_bubble=1; stay RUN. A pending interrupt waits one cycle so the saved PC is the branch target.
  2. int_pending: if_id_flush=1, id_ex_bubble=1, pc_write_en=0; cnt<=INT_CYCLES-1; go INT.
  3. pop_case_n=0: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. If POP_STALL_CYCLES>1, cnt<=POP_STALL_CYCLES-2 and go POP_STALL; else stay RUN.
  4. load_use_n=0: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; stay RUN. The one-cycle stall ends when the hazard logic releases.
- POP_STALL: freeze PC and IF/ID, id_ex_bubble=1. Ignores load_use_n, pop_case_n and int_pending.
  - branch_taken: flush as in RUN and go RUN (stall aborted).
  - cnt==0: go RUN; else cnt decrements.
- INT: if_id_flush=1, id_ex_bubble=1, pc_write_en=0 while cnt!=0; cnt decrements.
  - cnt==0: pc_sel_int=1, pc_write_en=1, int_ack=1, go RUN.
  - branch_taken is ignored in INT (already flushed on entry).
- Total cycles in INT equals INT_CYCLES, counting the entry cycle in RUN as cycle 0 not included.
- Reset asserted mid-sequence returns to RUN immediately and asynchronously. A pending interrupt is lost.

Test Plan:
- Reset, then idle 3 cycles → all enables 1, bubbles/flush 0, state=00.
- load_use_n=0 for 1 cycle → that cycle pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; next cycle defaults.
- pop_case_n=0 for 1 cycle, POP_STALL_CYCLES=3 → freeze+bubble for exactly 3 consecutive cycles; state 00→01→01→00.
- int_req pulse 1 cycle, INT_CYCLES=2 → entry cycle flush; next cycle flush; third cycle pc_sel_int=1, int_ack=1; state returns to 00.
- int_req and branch_taken in the same cycle → branch flush first with state=00; INT entered the following cycle; int_ack after INT_CYCLES.
- mem_busy=1 for 4 cycles during POP_STALL → ex_mem_write_en=0, mem_wb_bubble=1 for 4 cycles, cnt frozen. Remaining stall cycles resume afterward. rst pulse mid-INT → state=00, int_ack never asserted.
